// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer, program counter and memory model.
// Holds opcode values, FSM state encoding and bus widths.
package fetch_sequencer_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_JZ  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

endpackage

// File: rtl/fetch_sequencer_decode.sv
// Combinational jump decode: classifies the instruction register contents
// and resolves whether a jump is taken from the sampled zero flag.
module fetch_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] instr_i,
    input  logic              z_flag_i,
    output logic              is_jump_o,
    output logic              take_jump_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [1:0] opcode;

    assign opcode = instr_i[DATA_W-1 -: 2];

    always_comb begin
        is_jump_o   = (opcode == OP_JZ) || (opcode == OP_JMP);
        take_jump_o = (opcode == OP_JMP) || ((opcode == OP_JZ) && z_flag_i);
        target_o    = instr_i[ADDR_W-1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/issue sequencer: fetches from program memory, resolves jumps
// locally and drives the program counter load/increment strobe.
module fetch_sequencer #(
    parameter int DATA_W = fetch_sequencer_pkg::DATA_W,
    parameter int ADDR_W = fetch_sequencer_pkg::ADDR_W
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] PC_ADDR,
    output logic              MEM_REQ,
    input  logic              MEM_READY,
    input  logic [DATA_W-1:0] MEM_DATA,
    input  logic              Z_FLAG,
    output logic [DATA_W-1:0] INSTR,
    output logic              INSTR_VALID,
    input  logic              EXEC_READY,
    output logic              PC_ADVANCE,
    output logic              ADDR_WRITE,
    output logic [ADDR_W-1:0] ADDR_IN
);

    import fetch_sequencer_pkg::*;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              addr_wr_q, addr_wr_d;
    logic [ADDR_W-1:0] addr_in_q, addr_in_d;

    logic              is_jump;
    logic              take_jump;
    logic [ADDR_W-1:0] target;

    // PC_ADDR feeds program memory directly; the sequencer never inspects it.
    logic unused_pc_addr;
    assign unused_pc_addr = ^PC_ADDR;

    fetch_decode u_decode (
        .instr_i     (ir_q),
        .z_flag_i    (Z_FLAG),
        .is_jump_o   (is_jump),
        .take_jump_o (take_jump),
        .target_o    (target)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        addr_wr_d = addr_wr_q;
        addr_in_d = addr_in_q;
        unique case (state_q)
            S_FETCH: begin
                if (MEM_READY) begin
                    ir_d    = MEM_DATA;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_jump) begin
                    addr_wr_d = take_jump;
                    if (take_jump) begin
                        addr_in_d = target;
                    end
                    state_d = S_STEP;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (EXEC_READY) begin
                    addr_wr_d = 1'b0;
                    state_d   = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            addr_wr_q <= 1'b0;
            addr_in_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            addr_wr_q <= addr_wr_d;
            addr_in_q <= addr_in_d;
        end
    end

    // Request is masked during reset so the reset cycle never starts a fetch.
    assign MEM_REQ     = (state_q == S_FETCH) && !RESET;
    assign INSTR       = ir_q;
    assign INSTR_VALID = (state_q == S_ISSUE);
    assign PC_ADVANCE  = (state_q == S_STEP);
    assign ADDR_WRITE  = addr_wr_q;
    assign ADDR_IN     = addr_in_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps followed by random
// instructions checked against a transaction-level model of the sequencer.
module tb_fetch_sequencer;

    logic       clk;
    logic       RESET;
    logic [5:0] PC_ADDR;
    logic       MEM_REQ;
    logic       MEM_READY;
    logic [7:0] MEM_DATA;
    logic       Z_FLAG;
    logic [7:0] INSTR;
    logic       INSTR_VALID;
    logic       EXEC_READY;
    logic       PC_ADVANCE;
    logic       ADDR_WRITE;
    logic [5:0] ADDR_IN;

    int         n_asserts = 0;
    int         n_fail    = 0;
    logic [5:0] last_tgt;

    fetch_sequencer dut (
        .CLOCK       (clk),
        .RESET       (RESET),
        .PC_ADDR     (PC_ADDR),
        .MEM_REQ     (MEM_REQ),
        .MEM_READY   (MEM_READY),
        .MEM_DATA    (MEM_DATA),
        .Z_FLAG      (Z_FLAG),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .EXEC_READY  (EXEC_READY),
        .PC_ADVANCE  (PC_ADVANCE),
        .ADDR_WRITE  (ADDR_WRITE),
        .ADDR_IN     (ADDR_IN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One instruction, start to finish, entered at the start of a FETCH cycle.
    task automatic run_instr(input logic [7:0] data, input int mem_dly,
                             input int exec_dly, input logic z,
                             input logic ztog);
        logic is_jmp;
        logic take;
        is_jmp = data[7];
        take   = (data[7:6] == 2'b11) || (data[7:6] == 2'b10 && z);
        for (int i = 0; i < mem_dly; i++) begin
            MEM_READY  = 1'b0;
            MEM_DATA   = 8'($urandom);
            EXEC_READY = 1'($urandom);
            #1;
            check("wait_req", MEM_REQ, 1);
            check("wait_adv", PC_ADVANCE, 0);
            check("wait_vld", INSTR_VALID, 0);
            cyc();
        end
        MEM_READY = 1'b1;
        MEM_DATA  = data;
        #1;
        check("fetch_req", MEM_REQ, 1);
        cyc();
        MEM_READY = 1'($urandom);
        MEM_DATA  = 8'($urandom);
        Z_FLAG    = z;
        #1;
        check("dec_req", MEM_REQ, 0);
        check("dec_vld", INSTR_VALID, 0);
        check("dec_adv", PC_ADVANCE, 0);
        cyc();
        if (!is_jmp) begin
            for (int j = 0; j < exec_dly; j++) begin
                EXEC_READY = 1'b0;
                if (ztog) Z_FLAG = ~Z_FLAG;
                #1;
                check("iss_vld", INSTR_VALID, 1);
                check("iss_instr", INSTR, data);
                check("iss_adv", PC_ADVANCE, 0);
                check("iss_req", MEM_REQ, 0);
                cyc();
            end
            EXEC_READY = 1'b1;
            #1;
            check("acc_vld", INSTR_VALID, 1);
            check("acc_instr", INSTR, data);
            check("acc_adv", PC_ADVANCE, 0);
            cyc();
            EXEC_READY = 1'($urandom);
            #1;
            check("step_adv", PC_ADVANCE, 1);
            check("step_wr", ADDR_WRITE, 0);
            check("step_ain", ADDR_IN, last_tgt);
            check("step_vld", INSTR_VALID, 0);
        end else begin
            if (ztog) Z_FLAG = ~z;
            MEM_READY = 1'($urandom);
            #1;
            check("jstep_adv", PC_ADVANCE, 1);
            if (take) last_tgt = data[5:0];
            check("jstep_wr", ADDR_WRITE, take);
            check("jstep_ain", ADDR_IN, last_tgt);
            check("jstep_vld", INSTR_VALID, 0);
            check("jstep_req", MEM_REQ, 0);
        end
        cyc();
    endtask

    initial begin
        RESET      = 1'b1;
        PC_ADDR    = 6'd0;
        MEM_READY  = 1'b0;
        MEM_DATA   = 8'h00;
        Z_FLAG     = 1'b0;
        EXEC_READY = 1'b0;
        last_tgt   = 6'd0;
        #1;
        check("rst_req", MEM_REQ, 0);
        cyc();
        check("rst_instr", INSTR, 8'h00);
        check("rst_vld", INSTR_VALID, 0);
        check("rst_adv", PC_ADVANCE, 0);
        check("rst_wr", ADDR_WRITE, 0);
        check("rst_ain", ADDR_IN, 6'd0);
        cyc();
        RESET = 1'b0;
        #1;
        check("post_rst_req", MEM_REQ, 1);

        run_instr(8'h05, 0, 0, 1'b0, 1'b0);
        run_instr(8'hEA, 0, 0, 1'b0, 1'b0);
        run_instr(8'h91, 0, 0, 1'b1, 1'b1);
        run_instr(8'h91, 0, 0, 1'b0, 1'b1);
        run_instr(8'h4C, 5, 4, 1'b1, 1'b1);

        // Reset lands in ISSUE together with EXEC_READY.
        MEM_READY = 1'b1;
        MEM_DATA  = 8'h05;
        #1;
        cyc();
        MEM_READY = 1'b0;
        #1;
        cyc();
        EXEC_READY = 1'b1;
        RESET      = 1'b1;
        #1;
        check("ri_vld", INSTR_VALID, 1);
        check("ri_req", MEM_REQ, 0);
        cyc();
        check("ri_instr", INSTR, 8'h00);
        check("ri_vld2", INSTR_VALID, 0);
        check("ri_adv", PC_ADVANCE, 0);
        check("ri_wr", ADDR_WRITE, 0);
        check("ri_ain", ADDR_IN, 6'd0);
        last_tgt   = 6'd0;
        RESET      = 1'b0;
        EXEC_READY = 1'b0;
        #1;
        check("ri_resume", MEM_REQ, 1);

        // Reset in FETCH together with MEM_READY discards the word.
        MEM_READY = 1'b1;
        MEM_DATA  = 8'hEA;
        RESET     = 1'b1;
        #1;
        cyc();
        RESET     = 1'b0;
        MEM_READY = 1'b0;
        #1;
        check("rf_req", MEM_REQ, 1);
        check("rf_instr", INSTR, 8'h00);
        cyc();
        check("rf_req2", MEM_REQ, 1);
        check("rf_adv", PC_ADVANCE, 0);

        for (int k = 0; k < 40; k++) begin
            run_instr(8'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencer between the program counter and the execute stage. Takes the current 6-bit instruction address from the counter, fetches the 8-bit instruction word from program memory with a request/ready handshake, and resolves jumps locally. It drives the counter's load/increment controls and hands non-jump instructions to execute under a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 8, instruction word width (fixed; not to be overridden)
- ADDR_W, 6, instruction address width; must match the program counter

Ports:
- CLOCK  in  1  clock; all state changes on rising edge
- RESET  in  1  reset, synchronous, active-high
- PC_ADDR  in  6  current address from the program counter
- MEM_REQ  out  1  fetch request to program memory; memory address is PC_ADDR
- MEM_READY  in  1  memory has MEM_DATA valid this cycle
- MEM_DATA  in  8  instruction word from memory
- Z_FLAG  in  1  zero flag from execute; sampled in DECODE
- INSTR  out  8  instruction to execute
- INSTR_VALID  out  1  INSTR valid; held until accepted
- EXEC_READY  in  1  execute accepts INSTR this cycle
- PC_ADVANCE  out  1  one-cycle strobe; counter updates on the edge ending this cycle
- ADDR_WRITE  out  1  with PC_ADVANCE: 1 = load ADDR_IN, 0 = increment
- ADDR_IN  out  6  jump target for the counter

## Operation
- Instruction format: bits[7:6] opcode, bits[5:0] operand.
  - 00, 01: ordinary operations, forwarded to execute.
  - 10 JZ: jump to operand if Z_FLAG = 1, otherwise fall through.
  - 11 JMP: unconditional jump to operand.
- States: FETCH, DECODE, ISSUE, STEP.
- FETCH: MEM_REQ = 1. When MEM_READY = 1, latch MEM_DATA into the instruction register and go to DECODE. Otherwise stay.
- DECODE: MEM_REQ = 0.
  - JMP, or JZ with Z_FLAG = 1: ADDR_IN = operand, ADDR_WRITE = 1, go to STEP.
  - JZ with Z_FLAG = 0: ADDR_WRITE = 0, go to STEP.
  - Opcode 00 or 01: go to ISSUE.
- ISSUE: INSTR_VALID = 1 and INSTR = instruction register. When EXEC_READY = 1, ADDR_WRITE = 0 and go to STEP.
- STEP: PC_ADVANCE = 1 for exactly one cycle, then go to FETCH.
- ADDR_IN and ADDR_WRITE are registered. They hold their value from DECODE/ISSUE through STEP.
- Jumps are never presented to execute (INSTR_VALID stays 0).
- Address wrap 63 -> 0 on increment is the counter's behaviour; the sequencer does not special-case it.
- Jump to own address is legal and produces a tight loop.

## Timing
- Reset values: state = FETCH; MEM_REQ = 0 during the reset cycle, 1 from the first cycle after reset deasserts; INSTR = 0, INSTR_VALID = 0, PC_ADVANCE = 0, ADDR_WRITE = 0, ADDR_IN = 0.
- RESET has priority over every other input in the same cycle, including MEM_READY and EXEC_READY.
- RESET asserted mid-fetch or mid-issue discards the instruction. No PC_ADVANCE is emitted.
- Minimum loop, memory ready in the first cycle:
  - Jump: 3 cycles (FETCH, DECODE, STEP).
  - Ordinary instruction with EXEC_READY already high: 4 cycles (FETCH, DECODE, ISSUE, STEP).
- MEM_DATA is sampled only on the edge where MEM_REQ = 1 and MEM_READY = 1. MEM_READY outside FETCH is ignored.
- INSTR_VALID asserts on the cycle after DECODE. INSTR is stable while INSTR_VALID = 1 and EXEC_READY = 0. INSTR_VALID deasserts the cycle after acceptance.
- Z_FLAG is sampled only in DECODE. Later changes do not affect a decision already taken.
- PC_ADDR must be stable from FETCH entry until MEM_READY. This holds because the counter only moves on PC_ADVANCE.

## Structure
- Shared package holds:
  - Opcode constants: OP_JZ = 2'b10, OP_JMP = 2'b11.
  - State encoding: FETCH, DECODE, ISSUE, STEP.
  - ADDR_W = 6, DATA_W = 8, shared with the program counter and memory model.
- One combinational sub-module, fetch_decode: takes instruction and Z_FLAG, returns is_jump, take_jump, target.
- FSM and registers live in fetch_sequencer.

## Test plan
- Reset, then MEM_READY = 1 with MEM_DATA = 8'h05 and EXEC_READY = 1 -> INSTR = 8'h05 with INSTR_VALID for 1 cycle; PC_ADVANCE = 1 with ADDR_WRITE = 0 in the following cycle; MEM_REQ again on the next cycle.
- MEM_DATA = 8'hEA (JMP 42) -> INSTR_VALID never asserts; PC_ADVANCE = 1 with ADDR_WRITE = 1 and ADDR_IN = 42 exactly 2 cycles after MEM_READY.
- MEM_DATA = 8'h91 (JZ 17), run twice:
  - Z_FLAG = 1 -> ADDR_WRITE = 1, ADDR_IN = 17.
  - Z_FLAG = 0 -> ADDR_WRITE = 0.
  - Z_FLAG toggled after DECODE -> no change to the outcome.
- MEM_READY held low 5 cycles, then EXEC_READY held low 4 cycles -> MEM_REQ stays high and INSTR stays stable throughout; exactly one PC_ADVANCE per instruction.
- RESET asserted during ISSUE with EXEC_READY = 1 in the same cycle -> no PC_ADVANCE; all outputs at reset values next cycle; FETCH resumes.
